// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RISC-V core widths and the write-queue entry type.
package riscv_pkg;
    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    // One-hot register mask; x0 never maps to a bit so it can never be marked pending.
    function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_ADDR_W-1:0] rd);
        return (rd == '0) ? '0 : NUM_REGS'(1) << rd;
    endfunction
endpackage

// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if: result sources, issue tap and register-file write port of the writeback stage.
interface regfile_writeback_if;
    import riscv_pkg::*;
    logic                  i_mem_valid;
    logic [REG_ADDR_W-1:0] i_mem_rd;
    logic [XLEN-1:0]       i_mem_data;
    logic                  o_mem_ready;
    logic                  i_alu_valid;
    logic [REG_ADDR_W-1:0] i_alu_rd;
    logic [XLEN-1:0]       i_alu_data;
    logic                  o_alu_ready;
    logic                  i_issue_valid;
    logic [REG_ADDR_W-1:0] i_issue_rd;
    logic                  o_we;
    logic [REG_ADDR_W-1:0] o_rd;
    logic [XLEN-1:0]       o_data;
    logic [NUM_REGS-1:0]   o_pending;

    modport master (
        output i_mem_valid, i_mem_rd, i_mem_data, i_alu_valid, i_alu_rd, i_alu_data,
               i_issue_valid, i_issue_rd,
        input  o_mem_ready, o_alu_ready, o_we, o_rd, o_data, o_pending
    );
    modport slave (
        input  i_mem_valid, i_mem_rd, i_mem_data, i_alu_valid, i_alu_rd, i_alu_data,
               i_issue_valid, i_issue_rd,
        output o_mem_ready, o_alu_ready, o_we, o_rd, o_data, o_pending
    );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: DEPTH-entry write queue with two ordered push ports and one pop port.
module wb_fifo
    import riscv_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          i_clk,
    input  logic          i_resetn,
    input  logic          i_push0,
    input  wb_entry_t     i_ent0,
    input  logic          i_push1,
    input  wb_entry_t     i_ent1,
    input  logic          i_pop,
    output wb_entry_t     o_head,
    output logic [CW-1:0] o_count,
    output logic [CW-1:0] o_free
);
    wb_entry_t     r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [AW-1:0] w_wr1;

    // Port 1 lands behind port 0 when both push, preserving source order.
    assign w_wr1 = r_wr_ptr + AW'(i_push0);

    always_ff @(posedge i_clk) begin
        if (i_push0) r_mem[r_wr_ptr] <= i_ent0;
        if (i_push1) r_mem[w_wr1] <= i_ent1;
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= w_wr1 + AW'(i_push1);
            r_rd_ptr <= r_rd_ptr + AW'(i_pop);
            r_count  <= r_count + CW'(i_push0) + CW'(i_push1) - CW'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_free  = CW'(DEPTH) - r_count + CW'(i_pop);
endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: arbitrates load/ALU results into a write queue feeding the register file,
// and keeps a per-register write-pending scoreboard.
module regfile_writeback
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                i_clk,
    input  logic                i_resetn,
    regfile_writeback_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    wb_entry_t           w_head;
    logic [CW-1:0]       w_count;
    logic [CW-1:0]       w_free;
    logic                w_mem_fire;
    logic                w_mem_push;
    logic                w_alu_push;
    logic [NUM_REGS-1:0] r_pending;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk    (i_clk),
        .i_resetn (i_resetn),
        .i_push0  (w_mem_push),
        .i_ent0   ('{rd: bus.i_mem_rd, data: bus.i_mem_data}),
        .i_push1  (w_alu_push),
        .i_ent1   ('{rd: bus.i_alu_rd, data: bus.i_alu_data}),
        .i_pop    (bus.o_we),
        .o_head   (w_head),
        .o_count  (w_count),
        .o_free   (w_free)
    );

    assign bus.o_we   = w_count != '0;
    assign bus.o_rd   = bus.o_we ? w_head.rd : '0;
    assign bus.o_data = bus.o_we ? w_head.data : '0;

    // x0 results are accepted but never enqueued, so they do not consume a slot.
    assign bus.o_mem_ready = w_free >= CW'(1);
    assign w_mem_fire      = bus.i_mem_valid & bus.o_mem_ready;
    assign w_mem_push      = w_mem_fire & (bus.i_mem_rd != '0);
    assign bus.o_alu_ready = w_free >= CW'(1) + CW'(w_mem_push);
    assign w_alu_push      = bus.i_alu_valid & bus.o_alu_ready & (bus.i_alu_rd != '0);

    // o_rd is 0 when idle and reg_mask(0) is empty, so no extra o_we gating is needed.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) r_pending <= '0;
        else r_pending <= (r_pending & ~reg_mask(bus.o_rd))
                        | (bus.i_issue_valid ? reg_mask(bus.i_issue_rd) : '0);
    end

    assign bus.o_pending = r_pending;
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed checks of queueing, arbitration, backpressure, x0 drop,
// scoreboard and reset behaviour of regfile_writeback.
module tb_regfile_writeback;
    import riscv_pkg::*;
    localparam int DEPTH = 4;

    logic clk  = 0;
    logic rstn = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    regfile_writeback_if bus();
    regfile_writeback #(.DEPTH(DEPTH)) dut (.i_clk(clk), .i_resetn(rstn), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.i_mem_valid   = 0;
        bus.i_mem_rd      = 0;
        bus.i_mem_data    = 0;
        bus.i_alu_valid   = 0;
        bus.i_alu_rd      = 0;
        bus.i_alu_data    = 0;
        bus.i_issue_valid = 0;
        bus.i_issue_rd    = 0;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [63:0] d);
        bus.i_alu_valid = 1;
        bus.i_alu_rd    = rd;
        bus.i_alu_data  = d;
    endtask

    task automatic mem(input logic [4:0] rd, input logic [63:0] d);
        bus.i_mem_valid = 1;
        bus.i_mem_rd    = rd;
        bus.i_mem_data  = d;
    endtask

    wb_entry_t exp_q[$];
    int        cnt;
    int        fr;
    logic      m_acc;
    logic      a_acc;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        repeat (2) tick();
        check("rst_we",        bus.o_we, 0);
        check("rst_rd",        bus.o_rd, 0);
        check("rst_data",      bus.o_data, 0);
        check("rst_pending",   bus.o_pending, 0);
        check("rst_mem_ready", bus.o_mem_ready, 1);
        check("rst_alu_ready", bus.o_alu_ready, 1);
        check("rst_free",      dut.w_free, DEPTH);
        rstn = 1;
        tick();

        alu(5, 64'h1234);
        #1 check("alu_ready", bus.o_alu_ready, 1);
        tick();
        idle();
        check("alu_we",   bus.o_we, 1);
        check("alu_rd",   bus.o_rd, 5);
        check("alu_data", bus.o_data, 64'h1234);
        tick();
        check("alu_we_off", bus.o_we, 0);

        mem(3, 64'hAA);
        alu(3, 64'hBB);
        #1;
        check("dual_mem_ready", bus.o_mem_ready, 1);
        check("dual_alu_ready", bus.o_alu_ready, 1);
        tick();
        idle();
        check("dual_we0",   bus.o_we, 1);
        check("dual_rd0",   bus.o_rd, 3);
        check("dual_data0", bus.o_data, 64'hAA);
        tick();
        check("dual_we1",   bus.o_we, 1);
        check("dual_rd1",   bus.o_rd, 3);
        check("dual_data1", bus.o_data, 64'hBB);
        tick();
        check("dual_we_off", bus.o_we, 0);

        alu(0, 64'hFFFF);
        #1 check("x0_ready", bus.o_alu_ready, 1);
        tick();
        idle();
        check("x0_we",    bus.o_we, 0);
        check("x0_free",  dut.w_free, DEPTH);
        check("x0_count", dut.w_count, 0);

        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            mem(5'(k % 15 + 1), 64'h1000 + 64'(k));
            alu(5'(k % 15 + 16), 64'h2000 + 64'(k));
            #1;
            if (cnt > 0) begin
                check("bp_we",   bus.o_we, 1);
                check("bp_rd",   bus.o_rd, exp_q[0].rd);
                check("bp_data", bus.o_data, exp_q[0].data);
                void'(exp_q.pop_front());
            end else begin
                check("bp_we", bus.o_we, 0);
            end
            fr    = DEPTH - cnt + ((cnt > 0) ? 1 : 0);
            m_acc = fr >= 1;
            a_acc = fr >= 2;
            check("bp_mem_ready", bus.o_mem_ready, m_acc);
            check("bp_alu_ready", bus.o_alu_ready, a_acc);
            if (m_acc) exp_q.push_back('{rd: bus.i_mem_rd, data: bus.i_mem_data});
            if (a_acc) exp_q.push_back('{rd: bus.i_alu_rd, data: bus.i_alu_data});
            cnt = exp_q.size();
            tick();
            check("bp_count", dut.w_count, cnt);
        end
        idle();
        for (int k = 0; k < DEPTH + 2; k++) begin
            #1;
            if (exp_q.size() > 0) begin
                check("drain_we",   bus.o_we, 1);
                check("drain_rd",   bus.o_rd, exp_q[0].rd);
                check("drain_data", bus.o_data, exp_q[0].data);
                void'(exp_q.pop_front());
            end else begin
                check("drain_idle", bus.o_we, 0);
            end
            tick();
        end

        bus.i_issue_valid = 1;
        bus.i_issue_rd    = 7;
        tick();
        idle();
        check("sb_set", bus.o_pending, 32'h80);
        bus.i_issue_valid = 1;
        bus.i_issue_rd    = 0;
        tick();
        idle();
        check("sb_x0", bus.o_pending, 32'h80);
        alu(7, 64'h77);
        tick();
        idle();
        check("sb_we1", bus.o_we, 1);
        check("sb_rd1", bus.o_rd, 7);
        bus.i_issue_valid = 1;
        bus.i_issue_rd    = 7;
        tick();
        idle();
        check("sb_set_wins", bus.o_pending, 32'h80);
        alu(7, 64'h78);
        tick();
        idle();
        check("sb_we2",      bus.o_we, 1);
        check("sb_still_on", bus.o_pending, 32'h80);
        tick();
        check("sb_clear", bus.o_pending, 0);

        bus.i_issue_valid = 1;
        bus.i_issue_rd    = 9;
        mem(1, 64'h11);
        alu(2, 64'h22);
        tick();
        idle();
        mem(3, 64'h33);
        alu(4, 64'h44);
        tick();
        idle();
        check("mid_count",   dut.w_count, 3);
        check("mid_pending", bus.o_pending, 32'h200);
        #2 rstn = 0;
        #1;
        check("mid_rst_we",        bus.o_we, 0);
        check("mid_rst_rd",        bus.o_rd, 0);
        check("mid_rst_data",      bus.o_data, 0);
        check("mid_rst_pending",   bus.o_pending, 0);
        check("mid_rst_mem_ready", bus.o_mem_ready, 1);
        check("mid_rst_alu_ready", bus.o_alu_ready, 1);
        tick();
        check("mid_rst_hold_we", bus.o_we, 0);
        rstn = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post_rst_we", bus.o_we, 0);
        end
        alu(6, 64'h66);
        tick();
        idle();
        check("post_rst_new_we",   bus.o_we, 1);
        check("post_rst_new_rd",   bus.o_rd, 6);
        check("post_rst_new_data", bus.o_data, 64'h66);
        tick();
        check("post_rst_new_off", bus.o_we, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
